// File: rtl/keypad_if.sv
// keypad_if: keypad matrix pins plus debounced key code outputs
interface keypad_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [15:0] onehot;
  logic key_press;
  logic multi_key;
  modport master (output row_in, input col_out, onehot, key_press, multi_key);
  modport slave (input row_in, output col_out, onehot, key_press, multi_key);
endinterface

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: 4x4 keypad column scan, debounce and ghost rejection; KEYPAD_AUTOREPEAT_EN adds auto-repeat strobes
module keypad_scan_debounce #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE = 5
) (
  input logic clk,
  input logic rst,
  keypad_if.slave kp
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_param
    $error("keypad_scan_debounce: illegal parameter combination");
  end
  logic [3:0] row_m, row_s;
  logic [CW-1:0] dwell;
  logic [1:0] col;
  logic [15:0] raw, prev_raw, snap, cand, onehot_q;
  logic [SW-1:0] stable_cnt, stable_nxt;
  logic last, eos, commit, cand_mk, mk_q, kp_q, rpt_fire;
  assign kp.col_out = ~(4'b0001 << col);
  assign kp.onehot = onehot_q;
  assign kp.multi_key = mk_q;
  assign kp.key_press = kp_q;
  // snap is raw with the currently driven column replaced by the live sample
  always_comb begin
    snap = raw;
    for (int r = 0; r < 4; r++) snap[4*r+col] = ~row_s[r];
    last = dwell == CW'(SCAN_DIV - 1);
    eos = last && col == 2'd3;
    stable_nxt = snap != prev_raw ? SW'(1) :
                 stable_cnt == SW'(DEBOUNCE_SCANS) ? stable_cnt : stable_cnt + 1'b1;
    cand = $countones(snap) == 1 ? snap : '0;
    cand_mk = $countones(snap) > 1;
    commit = eos && stable_nxt == SW'(DEBOUNCE_SCANS) && (cand != onehot_q || cand_mk != mk_q);
  end
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rpt;
  assign rpt_fire = eos && !commit && onehot_q != '0 && rpt + 1'b1 == RW'(REPEAT_DELAY);
  always_ff @(posedge clk)
    if (rst || commit || onehot_q == '0 || mk_q) rpt <= '0;
    else if (eos) rpt <= rpt_fire ? RW'(REPEAT_DELAY - REPEAT_RATE) : rpt + 1'b1;
`else
  assign rpt_fire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      row_m <= '1;
      row_s <= '1;
      dwell <= '0;
      col <= '0;
      raw <= '0;
      prev_raw <= '0;
      stable_cnt <= '0;
      onehot_q <= '0;
      mk_q <= 1'b0;
      kp_q <= 1'b0;
    end else begin
      row_m <= kp.row_in;
      row_s <= row_m;
      dwell <= last ? '0 : dwell + 1'b1;
      if (last) begin
        col <= col + 1'b1;
        raw <= snap;
      end
      if (eos) begin
        stable_cnt <= stable_nxt;
        prev_raw <= snap;
      end
      if (commit) begin
        onehot_q <= cand;
        mk_q <= cand_mk;
      end
      kp_q <= (commit && cand != '0 && cand != onehot_q) || rpt_fire;
    end
  end
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce: scoreboard bench for keypad_scan_debounce with a key-matrix model
module tb_keypad_scan_debounce;
  localparam int SD = 4;
  localparam int SCAN = 4 * SD;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] keys = '0;
  int checks = 0;
  int fails = 0;
  logic [17:0] exp_q[$];
  logic mon_en = 1'b0;
  logic [16:0] last_seen;
  logic [17:0] mon_ev, mon_exp;
  always #5 clk = ~clk;
  keypad_if kp();
  keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(3), .REPEAT_DELAY(4), .REPEAT_RATE(2))
    dut (.clk(clk), .rst(rst), .kp(kp));
  always_comb begin
    kp.row_in = 4'hF;
    for (int r = 0; r < 4; r++) kp.row_in[r] = ~|(keys[4*r+:4] & ~kp.col_out);
  end
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, req);
    end
  endtask
  task automatic expect_ev(logic [15:0] oh, logic mk, logic kpr);
    exp_q.push_back({oh, mk, kpr});
  endtask
  task automatic drain(string name);
    for (int i = 0; i < 8 * SCAN && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      mon_ev = {kp.onehot, kp.multi_key, kp.key_press};
      if (kp.key_press || mon_ev[17:1] != last_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got onehot=%h mk=%b kp=%b, wanted none", mon_ev[17:2], mon_ev[1], mon_ev[0]);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_ev !== mon_exp) begin
            fails++;
            $display("FAIL event: got onehot=%h mk=%b kp=%b, wanted onehot=%h mk=%b kp=%b",
                     mon_ev[17:2], mon_ev[1], mon_ev[0], mon_exp[17:2], mon_exp[1], mon_exp[0]);
          end
        end
      end
      last_seen = mon_ev[17:1];
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [3:0] ec;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_col", kp.col_out, 4'b1110);
    check("reset_onehot", kp.onehot, 16'h0000);
    check("reset_kp", kp.key_press, 1'b0);
    check("reset_mk", kp.multi_key, 1'b0);
    last_seen = {kp.onehot, kp.multi_key};
    mon_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      repeat (SD) @(negedge clk);
      ec = ~(4'b0001 << (i % 4));
      check("col_rotate", kp.col_out, ec);
    end
    expect_ev(16'h0200, 1'b0, 1'b1);
    keys = 16'h0200;
    drain("press9");
    expect_ev(16'h0000, 1'b0, 1'b0);
    keys = 16'h0000;
    drain("release9");
    for (int i = 0; i < 3; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (2 * SCAN) @(negedge clk);
    end
    check("bounce_hold", kp.onehot, 16'h0000);
    expect_ev(16'h0200, 1'b0, 1'b1);
    drain("bounce_commit");
    expect_ev(16'h0000, 1'b1, 1'b0);
    keys = 16'h0021;
    drain("ghost");
    check("ghost_mk", kp.multi_key, 1'b1);
    expect_ev(16'h0001, 1'b0, 1'b1);
    keys = 16'h0001;
    drain("ghost_release");
    expect_ev(16'h8000, 1'b0, 1'b1);
    keys = 16'h8000;
    drain("press15");
    for (int i = 0; i < SCAN && kp.col_out != 4'b1011; i++) @(negedge clk);
    check("find_col2", kp.col_out, 4'b1011);
    repeat (2) @(negedge clk);
    expect_ev(16'h0000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset_col", kp.col_out, 4'b1110);
    check("mid_reset_onehot", kp.onehot, 16'h0000);
    expect_ev(16'h8000, 1'b0, 1'b1);
    drain("recommit15");
    expect_ev(16'h0008, 1'b0, 1'b1);
    keys = 16'h0008;
    drain("press3");
`ifdef KEYPAD_AUTOREPEAT_EN
    repeat (4) expect_ev(16'h0008, 1'b0, 1'b1);
`endif
    repeat (8 * SCAN) @(negedge clk);
    check("hold3_onehot", kp.onehot, 16'h0008);
    expect_ev(16'h0000, 1'b0, 1'b0);
    keys = 16'h0000;
    drain("release3");
    repeat (2 * SCAN) @(negedge clk);
    check("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
